// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill and
// dcache refill/writeback; each grant moves one cache line word by word.
module mem_arbiter #(
   parameter  int unsigned LINE_WORDS = 4,
   parameter  int unsigned ADDR_W     = 32,
   localparam int unsigned CW         = $clog2(LINE_WORDS)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     ic_req_i,
   input  logic [ADDR_W-1:0]        ic_addr_i,
   output logic [31:0]              ic_rdata_o,
   output logic                     ic_rvalid_o,
   output logic [CW-1:0]            ic_widx_o,
   output logic                     ic_done_o,
   input  logic                     dc_req_i,
   input  logic                     dc_we_i,
   input  logic [ADDR_W-1:0]        dc_addr_i,
   input  logic [32*LINE_WORDS-1:0] dc_wdata_i,
   output logic [31:0]              dc_rdata_o,
   output logic                     dc_rvalid_o,
   output logic [CW-1:0]            dc_widx_o,
   output logic                     dc_done_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic [31:0]              mem_wdata_o,
   input  logic [31:0]              mem_rdata_i,
   input  logic                     mem_ack_i
);

   localparam int unsigned   OFF      = CW + 2;
   localparam int unsigned   TW       = ADDR_W - OFF;
   localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;
   typedef enum logic {P_IC = 1'b0, P_DC = 1'b1} port_t;

   state_t        state;
   port_t         grant;
   port_t         last_grant;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tag;
   logic          we;

   port_t         pick;
   logic [TW-1:0] pick_tag;
   logic          pick_we;
   logic [CW-1:0] cnt_nxt;
   logic [31:0]   wword_nxt;

   // Offset bits inside the line are implied by the word counter.
   logic unused_low_bits;
   assign unused_low_bits = ^{ic_addr_i[OFF-1:0], dc_addr_i[OFF-1:0]};

   // Arbitration choice and next-word helpers.
   always_comb begin
      pick = P_IC;
      if (dc_req_i && (!ic_req_i || last_grant == P_IC)) begin
         pick = P_DC;
      end
      pick_tag  = (pick == P_DC) ? dc_addr_i[ADDR_W-1:OFF] : ic_addr_i[ADDR_W-1:OFF];
      pick_we   = (pick == P_DC) && dc_we_i;
      cnt_nxt   = cnt + CW'(1);
      wword_nxt = we ? dc_wdata_i[{cnt_nxt, 5'b00000} +: 32] : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         grant       <= P_IC;
         last_grant  <= P_DC;
         cnt         <= '0;
         tag         <= '0;
         we          <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         ic_rdata_o  <= '0;
         ic_rvalid_o <= 1'b0;
         ic_widx_o   <= '0;
         ic_done_o   <= 1'b0;
         dc_rdata_o  <= '0;
         dc_rvalid_o <= 1'b0;
         dc_widx_o   <= '0;
         dc_done_o   <= 1'b0;
      end else begin
         ic_rdata_o  <= '0;
         ic_rvalid_o <= 1'b0;
         ic_widx_o   <= '0;
         ic_done_o   <= 1'b0;
         dc_rdata_o  <= '0;
         dc_rvalid_o <= 1'b0;
         dc_widx_o   <= '0;
         dc_done_o   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ic_req_i || dc_req_i) begin
                  grant       <= pick;
                  tag         <= pick_tag;
                  we          <= pick_we;
                  cnt         <= '0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= pick_we;
                  mem_addr_o  <= {pick_tag, {OFF{1'b0}}};
                  mem_wdata_o <= pick_we ? dc_wdata_i[31:0] : 32'd0;
                  state       <= S_BURST;
               end
            end
            S_BURST: begin
               if (mem_ack_i) begin
                  cnt <= cnt_nxt;
                  if (!we) begin
                     if (grant == P_IC) begin
                        ic_rvalid_o <= 1'b1;
                        ic_rdata_o  <= mem_rdata_i;
                        ic_widx_o   <= cnt;
                     end else begin
                        dc_rvalid_o <= 1'b1;
                        dc_rdata_o  <= mem_rdata_i;
                        dc_widx_o   <= cnt;
                     end
                  end
                  if (cnt == LAST_IDX) begin
                     state       <= S_DONE;
                     last_grant  <= grant;
                     mem_req_o   <= 1'b0;
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= '0;
                     mem_wdata_o <= '0;
                     if (grant == P_IC) ic_done_o <= 1'b1;
                     else               dc_done_o <= 1'b1;
                  end else begin
                     mem_addr_o  <= {tag, cnt_nxt, 2'b00};
                     mem_wdata_o <= wword_nxt;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a line-level round-robin model predicts the
// memory word sequence, read returns and done pulses; a monitor checks them.
module tb_mem_arbiter;

   localparam int unsigned LW = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned CW = $clog2(LW);

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              ic_req_i;
   logic [AW-1:0]     ic_addr_i;
   logic [31:0]       ic_rdata_o;
   logic              ic_rvalid_o;
   logic [CW-1:0]     ic_widx_o;
   logic              ic_done_o;
   logic              dc_req_i;
   logic              dc_we_i;
   logic [AW-1:0]     dc_addr_i;
   logic [32*LW-1:0]  dc_wdata_i;
   logic [31:0]       dc_rdata_o;
   logic              dc_rvalid_o;
   logic [CW-1:0]     dc_widx_o;
   logic              dc_done_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [AW-1:0]     mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [31:0]       mem_rdata_i;
   logic              mem_ack_i;

   mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdata_o(ic_rdata_o),
      .ic_rvalid_o(ic_rvalid_o), .ic_widx_o(ic_widx_o), .ic_done_o(ic_done_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
      .dc_wdata_i(dc_wdata_i), .dc_rdata_o(dc_rdata_o), .dc_rvalid_o(dc_rvalid_o),
      .dc_widx_o(dc_widx_o), .dc_done_o(dc_done_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        last;
      logic        port;   // 0 = icache, 1 = dcache
   } mem_exp_t;

   typedef struct packed {
      logic [CW-1:0] widx;
      logic [31:0]   data;
   } rd_exp_t;

   mem_exp_t exp_mem[$];
   rd_exp_t  exp_ic[$];
   rd_exp_t  exp_dc[$];

   int   checks     = 0;
   int   failures   = 0;
   int   ack_mode   = 0;   // 0 always, 1 random, 2 fixed gap pattern
   int   data_mode  = 0;   // 0 = 0xA0+word index, 1 = address hash
   int   mem_pops   = 0;
   bit   abort      = 1'b0;
   logic model_last = 1'b1;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (data_mode == 0) return 32'hA0 + ((a >> 2) & 32'(LW - 1));
      return a ^ 32'h5EED_0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem"},  64'({mem_req_o, mem_we_o, mem_wdata_o}), 64'(0));
      chk({tag, "_addr"}, 64'(mem_addr_o), 64'(0));
      chk({tag, "_ic"},   64'({ic_rdata_o, ic_rvalid_o, ic_widx_o, ic_done_o}), 64'(0));
      chk({tag, "_dc"},   64'({dc_rdata_o, dc_rvalid_o, dc_widx_o, dc_done_o}), 64'(0));
   endtask

   // Expected memory words and read returns for one line transfer.
   task automatic push_burst(input logic port, input logic [31:0] addr, input logic we,
                             input logic [32*LW-1:0] wd);
      logic [31:0] base;
      mem_exp_t    e;
      rd_exp_t     r;
      base = addr & ~32'(LW * 4 - 1);
      for (int w = 0; w < int'(LW); w++) begin
         e.addr  = base + 32'(4 * w);
         e.we    = we;
         e.wdata = we ? wd[32*w +: 32] : 32'd0;
         e.last  = (w == int'(LW) - 1);
         e.port  = port;
         exp_mem.push_back(e);
         if (!we) begin
            r.widx = CW'(w);
            r.data = mem_data(e.addr);
            if (port) exp_dc.push_back(r);
            else      exp_ic.push_back(r);
         end
      end
   endtask

   task automatic wait_dones(input bit need_ic, input bit need_dc);
      bit got_ic;
      bit got_dc;
      int n;
      got_ic = !need_ic;
      got_dc = !need_dc;
      n = 0;
      while (!(got_ic && got_dc)) begin
         @(negedge clk_i); #1;
         if (n == 0) chk("req_latency", 64'(mem_req_o), 64'(1));
         if (ic_done_o) begin got_ic = 1'b1; ic_req_i = 1'b0; end
         if (dc_done_o) begin got_dc = 1'b1; dc_req_i = 1'b0; end
         n++;
         if (n > 400) begin
            failures++;
            $display("FAIL done_timeout actual=none required=done at t=%0t", $time);
            abort = 1'b1;
            ic_req_i = 1'b0;
            dc_req_i = 1'b0;
            break;
         end
      end
      repeat (2) begin @(negedge clk_i); #1; end
   endtask

   // Line-level round-robin model: whoever was not served last goes first.
   task automatic run_round(input bit ic_on, input bit dc_on, input logic [31:0] ica,
                            input logic [31:0] dca, input logic we, input logic [32*LW-1:0] wd);
      if (ic_on && dc_on) begin
         if (model_last) begin
            push_burst(1'b0, ica, 1'b0, wd);
            push_burst(1'b1, dca, we, wd);
            model_last = 1'b1;
         end else begin
            push_burst(1'b1, dca, we, wd);
            push_burst(1'b0, ica, 1'b0, wd);
            model_last = 1'b0;
         end
      end else if (ic_on) begin
         push_burst(1'b0, ica, 1'b0, wd);
         model_last = 1'b0;
      end else begin
         push_burst(1'b1, dca, we, wd);
         model_last = 1'b1;
      end
      ic_addr_i  = ica;
      dc_addr_i  = dca;
      dc_we_i    = we;
      dc_wdata_i = wd;
      ic_req_i   = ic_on;
      dc_req_i   = dc_on;
      wait_dones(ic_on, dc_on);
      chk("round_drain", 64'(exp_mem.size() + exp_ic.size() + exp_dc.size()), 64'(0));
   endtask

   // Memory responder: drives ack per mode, junk data on cycles without ack.
   initial begin
      int bcyc;
      bcyc = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(negedge clk_i); #1;
         bcyc = mem_req_o ? bcyc + 1 : 0;
         case (ack_mode)
            0:       mem_ack_i = 1'b1;
            1:       mem_ack_i = ($urandom_range(0, 3) != 0);
            2:       mem_ack_i = (bcyc == 1 || bcyc == 4 || bcyc == 5 || bcyc == 9);
            default: mem_ack_i = 1'b0;
         endcase
         mem_rdata_i = mem_ack_i ? mem_data(mem_addr_o) : $urandom;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an output.
   initial begin
      mem_exp_t    e;
      rd_exp_t     r;
      logic        prev_req   = 1'b0;
      logic        prev_ack   = 1'b0;
      logic [31:0] prev_addr  = '0;
      logic [31:0] prev_wdata = '0;
      int          low_cnt    = 0;
      bit          seen       = 1'b0;
      bit          done_pend  = 1'b0;
      logic        done_port  = 1'b0;
      forever begin
         @(negedge clk_i); #2;
         if (!rst_ni) begin
            prev_req  = 1'b0;
            prev_ack  = 1'b0;
            done_pend = 1'b0;
            seen      = 1'b0;
            low_cnt   = 0;
         end else begin
            if (done_pend) begin
               chk("done_port", 64'({ic_done_o, dc_done_o}), 64'(done_port ? 2'b01 : 2'b10));
               done_pend = 1'b0;
            end else if (ic_done_o || dc_done_o) begin
               chk("spurious_done", 64'({ic_done_o, dc_done_o}), 64'(0));
            end
            if (ic_rvalid_o) begin
               if (exp_ic.size() == 0) chk("ic_rvalid_unexpected", 64'(1), 64'(0));
               else begin
                  r = exp_ic.pop_front();
                  chk("ic_rword", 64'({ic_widx_o, ic_rdata_o}), 64'(r));
               end
            end
            if (dc_rvalid_o) begin
               if (exp_dc.size() == 0) chk("dc_rvalid_unexpected", 64'(1), 64'(0));
               else begin
                  r = exp_dc.pop_front();
                  chk("dc_rword", 64'({dc_widx_o, dc_rdata_o}), 64'(r));
               end
            end
            if (mem_req_o && !prev_req) begin
               if (seen) chk("req_gap_ge2", 64'(low_cnt >= 2), 64'(1));
               seen = 1'b1;
            end
            low_cnt = mem_req_o ? 0 : low_cnt + 1;
            if (mem_req_o && prev_req && !prev_ack) begin
               chk("addr_hold", 64'(mem_addr_o), 64'(prev_addr));
               chk("wdata_hold", 64'(mem_wdata_o), 64'(prev_wdata));
            end
            if (mem_req_o && mem_ack_i) begin
               if (exp_mem.size() == 0) chk("mem_unexpected", 64'(1), 64'(0));
               else begin
                  e = exp_mem.pop_front();
                  chk("mem_addr", 64'(mem_addr_o), 64'(e.addr));
                  chk("mem_we", 64'(mem_we_o), 64'(e.we));
                  chk("mem_wdata", 64'(mem_wdata_o), 64'(e.wdata));
                  mem_pops++;
                  if (e.last) begin
                     done_pend = 1'b1;
                     done_port = e.port;
                  end
               end
            end
            prev_req   = mem_req_o;
            prev_ack   = mem_ack_i;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32*LW-1:0] wd;
      int               sel;
      int               p0;
      int               n;
      rst_ni     = 1'b0;
      ic_req_i   = 1'b0;
      dc_req_i   = 1'b0;
      dc_we_i    = 1'b0;
      ic_addr_i  = '0;
      dc_addr_i  = '0;
      dc_wdata_i = '0;
      repeat (3) @(negedge clk_i);
      #1;
      check_all_zero("reset");
      rst_ni = 1'b1;

      // Ack while idle must be ignored.
      ack_mode = 0;
      repeat (4) begin
         @(negedge clk_i); #1;
         chk("idle_ack", 64'({mem_req_o, ic_rvalid_o, dc_rvalid_o}), 64'(0));
      end

      // Single icache line read.
      data_mode = 0;
      wd = '0;
      run_round(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0, wd);

      // Dcache writeback.
      for (int w = 0; w < int'(LW); w++) wd[32*w +: 32] = 32'hD0D0_0000 + 32'(w);
      run_round(1'b0, 1'b1, 32'h0, 32'h0000_2008, 1'b1, wd);

      // Contention, twice: grants alternate.
      data_mode = 1;
      run_round(1'b1, 1'b1, 32'h0001_0040, 32'h0002_0080, 1'b0, wd);
      run_round(1'b1, 1'b1, 32'h0003_00C0, 32'h0004_0100, 1'b1, wd);

      // Ack with gaps.
      ack_mode = 2;
      run_round(1'b1, 1'b0, 32'h0000_3F34, 32'h0, 1'b0, wd);
      run_round(1'b0, 1'b1, 32'h0, 32'h0000_5A50, 1'b1, wd);
      ack_mode = 0;

      // Asynchronous reset in the middle of an icache burst.
      push_burst(1'b0, 32'h0000_7700, 1'b0, wd);
      ic_addr_i = 32'h0000_7700;
      ic_req_i  = 1'b1;
      p0 = mem_pops;
      n  = 0;
      while (mem_pops - p0 < 2 && n < 50) begin
         @(negedge clk_i); #3;
         n++;
      end
      chk("reset_burst_started", 64'(mem_pops - p0 >= 2), 64'(1));
      @(posedge clk_i); #2;
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_mem.delete();
      exp_ic.delete();
      exp_dc.delete();
      repeat (2) @(negedge clk_i);
      #1;
      model_last = 1'b0;
      push_burst(1'b0, 32'h0000_7700, 1'b0, wd);
      rst_ni = 1'b1;
      wait_dones(1'b1, 1'b0);
      chk("restart_drain", 64'(exp_mem.size() + exp_ic.size() + exp_dc.size()), 64'(0));

      // Randomised rounds.
      for (int k = 0; k < 40 && !abort; k++) begin
         sel      = $urandom_range(1, 3);
         ack_mode = $urandom_range(0, 1);
         for (int w = 0; w < int'(LW); w++) wd[32*w +: 32] = $urandom;
         run_round(sel[0], sel[1], $urandom, $urandom, 1'($urandom_range(0, 1)), wd);
      end

      chk("final_drain", 64'(exp_mem.size() + exp_ic.size() + exp_dc.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and burst sequencer that shares one backing memory port between the instruction-cache refill path and the data-cache refill/writeback path. Each granted request moves one full cache line as LINE_WORDS single-word transfers on the memory request/acknowledge interface. The block sits between the direct-mapped caches and the main instruction/data memory.

## Interface
- LINE_WORDS, 4: words per line; power of two, 2..16
- ADDR_W, 32: byte-address width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- ic_req_i  in  1  icache line-read request; held until ic_done_o
- ic_addr_i  in  ADDR_W  icache line address; low log2(LINE_WORDS)+2 bits ignored
- ic_rdata_o  out  32  returned word
- ic_rvalid_o  out  1  ic_rdata_o valid, 1-cycle pulse per word
- ic_widx_o  out  log2(LINE_WORDS)  word index of ic_rdata_o
- ic_done_o  out  1  line complete, 1-cycle pulse
- dc_req_i  in  1  dcache request; held until dc_done_o
- dc_we_i  in  1  1 = line write (writeback), 0 = line read
- dc_addr_i  in  ADDR_W  dcache line address, low bits ignored
- dc_wdata_i  in  32*LINE_WORDS  write line, word 0 in bits [31:0]; stable while dc_req_i high
- dc_rdata_o, dc_rvalid_o, dc_widx_o, dc_done_o  out  as icache equivalents
- mem_req_o  out  1  memory transfer request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  word-aligned byte address
- mem_wdata_o  out  32  write word
- mem_rdata_i  in  32  read word, valid with mem_ack_i
- mem_ack_i  in  1  current word accepted/returned

## Operation
- States IDLE, BURST, DONE. Registers: state, grant (IC/DC), last_grant, word counter cnt, line base, captured read data.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the port that is not last_grant. Latch line base (address with low bits zeroed), we (dc_we_i for DC, 0 for IC), cnt=0 -> BURST. last_grant resets to DC, so IC wins the first contention.
- BURST: mem_req_o=1, mem_addr_o=base+4*cnt, mem_we_o=latched we, mem_wdata_o=dc_wdata_i word cnt (0 when not writing). On mem_ack_i: capture mem_rdata_i, cnt++; ack on word LINE_WORDS-1 -> DONE, last_grant<=grant.
- Read data: the cycle after each ack the granted port's rvalid_o=1, rdata_o=captured word, widx_o=index of acked word. Writes produce no rvalid.
- DONE (one cycle): granted done_o=1, mem_req_o=0 -> IDLE.
- Requester deasserts req the cycle after done_o; req still high in IDLE is a new request and competes normally.
- Non-granted port outputs stay 0. Requests arriving during BURST/DONE wait; they are not lost because req is level.
- cnt wraps naturally at LINE_WORDS; no address carry beyond the line.

## Timing
- Reset (async, any state): state=IDLE, cnt=0, last_grant=DC; all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, all rdata/rvalid/widx/done). A burst in progress is abandoned; no done_o is issued.
- req sampled at edge T in IDLE -> mem_req_o high from T+1.
- Ack every cycle: one word per cycle; a line takes LINE_WORDS cycles in BURST plus one in DONE; next grant can be issued at the DONE->IDLE edge, so mem_req_o is low for at least 2 cycles between bursts.
- mem_addr_o advances on the edge that samples ack; ack gaps stall the burst with address/data held.
- Last-word rvalid_o coincides with done_o in DONE.
- mem_ack_i outside BURST is ignored.

## Test plan
- IC only, ic_addr_i=0x0000_0104, ack every cycle, mem returns 0xA0+idx -> mem_addr_o 0x100,0x104,0x108,0x10C; ic_rvalid_o 4 consecutive cycles widx 0..3 data 0xA0..0xA3; ic_done_o with last word; dc outputs 0.
- DC write, dc_addr_i=0x2008, dc_wdata_i={D3,D2,D1,D0} -> mem_we_o=1, addresses 0x2000..0x200C with D0..D3; no dc_rvalid_o; dc_done_o once.
- Both requests in first cycle after reset -> IC burst first, then DC; both held asserted again -> grants alternate IC, DC, IC.
- Ack with gaps (ack on cycles 1,4,5,9 of burst) -> mem_addr_o holds between acks, 4 rvalids total, done_o one cycle after final ack.
- rst_ni low mid-burst after 2 acks -> all outputs 0 immediately (asynchronous); after release with ic_req_i high, burst restarts at word 0, IC granted.
- ack asserted while IDLE -> no rvalid, no state change.
